spi_flash_arbiter: RTL

SPI_FLASH_ARBITER -- requirements
Module: spi_flash_arbiter

---
 rtl/spi_flash_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/spi_flash_arbiter.sv
// Two-port read arbiter in front of a single-transaction SPI flash core.
// A one-entry last-word buffer answers repeat reads without touching flash.
module spi_flash_arbiter #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned BUF_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_rstrb,
    input  logic [ADDR_W-1:0] a_addr,
    output logic [31:0]       a_rdata,
    output logic              a_rbusy,
    input  logic              b_rstrb,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [31:0]       b_rdata,
    output logic              b_rbusy,
    input  logic              inv,
    output logic [ADDR_W-1:0] f_word_address,
    output logic              f_rstrb,
    input  logic [31:0]       f_rdata,
    input  logic              f_rbusy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e            state_q, state_d;
    logic              pend_a_q, pend_a_d, pend_b_q, pend_b_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [31:0]       rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
    logic              last_q, last_d;      // 1: B won the most recent tie
    logic              sel_q, sel_d;        // port in service, 1: B
    logic              hit_q, hit_d;
    logic [ADDR_W-1:0] f_addr_q, f_addr_d;
    logic              f_rstrb_q, f_rstrb_d;
    logic              buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [31:0]       buf_data_q, buf_data_d;
    logic              inv_seen_q, inv_seen_d;

    logic              gnt_b;
    logic [ADDR_W-1:0] gnt_addr;
    logic              buf_hit;

    assign gnt_b    = pend_b_q && (!pend_a_q || !last_q);
    assign gnt_addr = gnt_b ? addr_b_q : addr_a_q;
    assign buf_hit  = (BUF_EN != 0) && buf_valid_q && (gnt_addr == buf_addr_q);

    always_comb begin
        state_d     = state_q;
        pend_a_d    = pend_a_q;
        pend_b_d    = pend_b_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        rdata_a_d   = rdata_a_q;
        rdata_b_d   = rdata_b_q;
        last_d      = last_q;
        sel_d       = sel_q;
        hit_d       = hit_q;
        f_addr_d    = f_addr_q;
        f_rstrb_d   = f_rstrb_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        inv_seen_d  = inv_seen_q;

        if (a_rstrb && !pend_a_q) begin
            pend_a_d = 1'b1;
            addr_a_d = a_addr;
        end
        if (b_rstrb && !pend_b_q) begin
            pend_b_d = 1'b1;
            addr_b_d = b_addr;
        end
        if (inv) begin
            buf_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (hit_q) begin
                    // Hit was decided last cycle; the buffered word is delivered now.
                    if (sel_q) begin
                        rdata_b_d = buf_data_q;
                        pend_b_d  = 1'b0;
                    end else begin
                        rdata_a_d = buf_data_q;
                        pend_a_d  = 1'b0;
                    end
                    hit_d = 1'b0;
                end else if ((pend_a_q || pend_b_q) && !f_rbusy) begin
                    sel_d = gnt_b;
                    // The pointer only moves on contested grants, so repeated ties alternate.
                    if (pend_a_q && pend_b_q) begin
                        last_d = gnt_b;
                    end
                    if (buf_hit) begin
                        hit_d = 1'b1;
                    end else begin
                        f_addr_d   = gnt_addr;
                        f_rstrb_d  = 1'b1;
                        inv_seen_d = 1'b0;
                        state_d    = StIssue;
                    end
                end
            end
            StIssue: begin
                f_rstrb_d  = 1'b0;
                inv_seen_d = inv_seen_q | inv;
                state_d    = StWait;
            end
            StWait: begin
                inv_seen_d = inv_seen_q | inv;
                if (!f_rbusy) begin
                    if (sel_q) begin
                        rdata_b_d = f_rdata;
                        pend_b_d  = 1'b0;
                    end else begin
                        rdata_a_d = f_rdata;
                        pend_a_d  = 1'b0;
                    end
                    if ((BUF_EN != 0) && !inv_seen_q && !inv) begin
                        buf_valid_d = 1'b1;
                        buf_addr_d  = f_addr_q;
                        buf_data_d  = f_rdata;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            pend_a_q    <= 1'b0;
            pend_b_q    <= 1'b0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            rdata_a_q   <= '0;
            rdata_b_q   <= '0;
            last_q      <= 1'b1;
            sel_q       <= 1'b0;
            hit_q       <= 1'b0;
            f_addr_q    <= '0;
            f_rstrb_q   <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            inv_seen_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_a_q    <= pend_a_d;
            pend_b_q    <= pend_b_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            rdata_a_q   <= rdata_a_d;
            rdata_b_q   <= rdata_b_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            hit_q       <= hit_d;
            f_addr_q    <= f_addr_d;
            f_rstrb_q   <= f_rstrb_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            inv_seen_q  <= inv_seen_d;
        end
    end

    assign a_rdata        = rdata_a_q;
    assign b_rdata        = rdata_b_q;
    assign a_rbusy        = pend_a_q;
    assign b_rbusy        = pend_b_q;
    assign f_word_address = f_addr_q;
    assign f_rstrb        = f_rstrb_q;

endmodule
